// File: rtl/adder_seq_nbit.sv
// adder_seq_nbit
//   Multi-cycle unsigned adder for wide operands. Each cycle in ADD adds one
//   CHUNK_WIDTH slice of the operands plus the carry from the previous slice,
//   so the carry chain per cycle is only CHUNK_WIDTH bits long.
//   The request is accepted in IDLE or DONE. Operands are latched on accept,
//   so later changes on a/b/carry_in do not disturb the operation in flight.
//
// Ports
//   clk       in   1          system clock, rising edge
//   n_rst     in   1          asynchronous active-low reset
//   start     in   1          request; honoured only in IDLE or DONE
//   a, b      in   BIT_WIDTH  operands, latched on accepted start
//   carry_in  in   1          carry into bit 0, latched on accepted start
//   busy      out  1          high while the chunks are being added
//   done      out  1          one-cycle pulse when sum/overflow were just updated
//   sum       out  BIT_WIDTH  registered result, held until the next completion
//   overflow  out  1          registered carry out of the MSB, held with sum

module adder_seq_nbit #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
  // A single-chunk configuration still needs a 1-bit counter so the vector is legal.
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if ((BIT_WIDTH % CHUNK_WIDTH) != 0) begin : g_width_check
    $error("adder_seq_nbit: BIT_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   op_a_q, op_a_d;
  logic [BIT_WIDTH-1:0]   op_b_q, op_b_d;
  logic [BIT_WIDTH-1:0]   work_q, work_d;
  logic [BIT_WIDTH-1:0]   sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [CHUNK_WIDTH-1:0] a_chunk;
  logic [CHUNK_WIDTH-1:0] b_chunk;
  logic [CHUNK_WIDTH:0]   chunk_sum;
  logic                   accept;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    work_d     = work_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    a_chunk    = '0;
    b_chunk    = '0;

    // Select the operand slice addressed by the chunk counter; chunk 0 holds the LSBs.
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_chunk = op_a_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk = op_b_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end

    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
    accept    = ((state_q == IDLE) || (state_q == DONE)) && start;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = ADD;
          op_a_d  = a;
          op_b_d  = b;
          carry_d = carry_in;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            work_d[k*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
          end
        end
        carry_d = chunk_sum[CHUNK_WIDTH];
        // The published result takes work_d so that the final chunk written this cycle is included.
        if (cnt_q == LAST_CNT) begin
          state_d    = DONE;
          sum_d      = work_d;
          overflow_d = chunk_sum[CHUNK_WIDTH];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      work_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      work_q     <= work_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = (state_q == ADD);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign overflow = overflow_q;

  a_known_operands: assert property (
    @(posedge clk) disable iff (!n_rst) accept |-> !$isunknown({a, b, carry_in})
  ) else $error("adder_seq_nbit: X/Z on a, b or carry_in at accepted start");

endmodule
